mem_bus_arbiter: RTL and testbench

Arbitrates the instruction-fetch port and the MEM-stage data port onto a single Wishbone-style memory bus with variable wait states. Sits between the pipeline (IF and MEM stages) and the external memory. Sequences one bus transaction at a time, registers read results, and raises per-port stall requests to the pipeline controller until each access completes.

---
 rtl/mem_bus_arbiter_pkg.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM to single-bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int REG_BUS_W = 32;

  // Byte-lane mask for full-word instruction fetches.
  localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_BUS_INST  = 3'd1,
    ARB_BUS_DATA  = 3'd2,
    ARB_DONE_INST = 3'd3,
    ARB_DONE_DATA = 3'd4
  } arb_state_e;

  // Everything the bus needs to see for one transaction, held stable while cyc is up.
  typedef struct packed {
    logic                 we;
    logic [3:0]           sel;
    logic [REG_BUS_W-1:0] addr;
    logic [REG_BUS_W-1:0] data;
  } bus_req_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_req_t fetch_req(input logic [REG_BUS_W-1:0] addr);
    bus_req_t r;
    r.we   = 1'b0;
    r.sel  = BUS_SEL_ALL;
    r.addr = addr;
    r.data = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one Wishbone-style
// bus, one transaction at a time. Data wins ties. Read results are buffered and
// presented for exactly one DONE cycle; a flush seen during a fetch drops it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  // instruction-fetch port
  input  logic                 if_ce_i,
  input  logic [REG_BUS_W-1:0] if_addr_i,
  output logic [REG_BUS_W-1:0] if_data_o,
  output logic                 if_stallreq_o,
  // MEM-stage data port
  input  logic                 mem_ce_i,
  input  logic                 mem_we_i,
  input  logic [3:0]           mem_sel_i,
  input  logic [REG_BUS_W-1:0] mem_addr_i,
  input  logic [REG_BUS_W-1:0] mem_data_i,
  output logic [REG_BUS_W-1:0] mem_data_o,
  output logic                 mem_stallreq_o,
  // external memory bus
  output logic                 bus_cyc_o,
  output logic                 bus_stb_o,
  output logic                 bus_we_o,
  output logic [3:0]           bus_sel_o,
  output logic [REG_BUS_W-1:0] bus_addr_o,
  output logic [REG_BUS_W-1:0] bus_data_o,
  input  logic [REG_BUS_W-1:0] bus_data_i,
  input  logic                 bus_ack_i
);

  arb_state_e           state_q,      state_d;
  logic                 cyc_q,        cyc_d;
  bus_req_t             req_q,        req_d;
  logic [REG_BUS_W-1:0] if_buf_q,     if_buf_d;
  logic [REG_BUS_W-1:0] mem_buf_q,    mem_buf_d;
  logic                 flush_seen_q, flush_seen_d;

  // Next-state logic: grant from IDLE, wait for ack, present the result for one cycle.
  always_comb begin
    // NOTE: every *_d gets its hold value first so no branch can infer a latch.
    state_d      = state_q;
    cyc_d        = cyc_q;
    req_d        = req_q;
    if_buf_d     = if_buf_q;
    mem_buf_d    = mem_buf_q;
    flush_seen_d = flush_seen_q;

    case (state_q)
      ARB_IDLE: begin
        flush_seen_d = 1'b0;
        if (mem_ce_i) begin
          state_d = ARB_BUS_DATA;
          cyc_d   = 1'b1;
          req_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, data: mem_data_i};
        end else if (if_ce_i && !flush_i) begin
          state_d = ARB_BUS_INST;
          cyc_d   = 1'b1;
          req_d   = fetch_req(if_addr_i);
        end
      end

      ARB_BUS_INST: begin
        // A flush anywhere in the fetch window makes the fetched word stale.
        flush_seen_d = flush_seen_q | flush_i;
        if (bus_ack_i) begin
          cyc_d    = 1'b0;
          if_buf_d = bus_data_i;
          state_d  = (flush_seen_q || flush_i) ? ARB_IDLE : ARB_DONE_INST;
        end
      end

      ARB_BUS_DATA: begin
        // Flush is ignored here: the data access must always complete.
        if (bus_ack_i) begin
          cyc_d     = 1'b0;
          mem_buf_d = bus_data_i;
          state_d   = ARB_DONE_DATA;
        end
      end

      ARB_DONE_INST, ARB_DONE_DATA: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and bus registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q      <= ARB_IDLE;
      cyc_q        <= 1'b0;
      req_q        <= '0;
      // NOTE: the read buffers are ordinary registers, so they join the reset and
      // the data outputs are defined from the first cycle.
      if_buf_q     <= '0;
      mem_buf_q    <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      req_q        <= req_d;
      if_buf_q     <= if_buf_d;
      mem_buf_q    <= mem_buf_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = cyc_q;
  assign bus_we_o   = req_q.we;
  assign bus_sel_o  = req_q.sel;
  assign bus_addr_o = req_q.addr;
  assign bus_data_o = req_q.data;

  // Results are visible only in the matching DONE cycle, zero otherwise.
  assign if_data_o  = (state_q == ARB_DONE_INST) ? if_buf_q  : '0;
  assign mem_data_o = (state_q == ARB_DONE_DATA) ? mem_buf_q : '0;

  // Each port stalls until the cycle its own result is presented.
  assign if_stallreq_o  = if_ce_i  && (state_q != ARB_DONE_INST);
  assign mem_stallreq_o = mem_ce_i && (state_q != ARB_DONE_DATA);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus
// transactions and completions; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;

  mem_bus_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_data_o     (if_data_o),
    .if_stallreq_o (if_stallreq_o),
    .mem_ce_i      (mem_ce_i),
    .mem_we_i      (mem_we_i),
    .mem_sel_i     (mem_sel_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .mem_stallreq_o(mem_stallreq_o),
    .bus_cyc_o     (bus_cyc_o),
    .bus_stb_o     (bus_stb_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_data_o    (bus_data_o),
    .bus_data_i    (bus_data_i),
    .bus_ack_i     (bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_data;
  } bus_exp_t;

  typedef struct packed {
    logic        is_data;
    logic        chk_data;
    logic [31:0] data;
  } done_exp_t;

  bus_exp_t    bus_exp_q[$];
  done_exp_t   done_exp_q[$];
  logic [31:0] rdata_q[$];

  int checks = 0;
  int errors = 0;
  int ack_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus slave: acks ack_wait cycles after strobe, read data from rdata_q.
  int wait_cnt  = 0;
  bit ack_given = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_ack_i  = 1'b0;
      bus_data_i = 32'hFFFF_0000;
      if (!bus_cyc_o) begin
        wait_cnt  = 0;
        ack_given = 1'b0;
      end else if (bus_stb_o && !ack_given) begin
        if (wait_cnt >= ack_wait) begin
          bus_ack_i = 1'b1;
          if (rdata_q.size() > 0) bus_data_i = rdata_q.pop_front();
          else bus_data_i = 32'h0;
          ack_given = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor / scoreboard.
  bus_exp_t  prev_req;
  bus_exp_t  be;
  done_exp_t de;
  bit        prev_hold = 1'b0;
  bit        ack_last  = 1'b0;
  bit        mem_done, if_done;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      ack_last  = 1'b0;
    end else begin
      check("stb_eq_cyc", 32'(bus_stb_o), 32'(bus_cyc_o));
      if (ack_last) check("cyc_drop_after_ack", 32'(bus_cyc_o), 32'h0);
      if (bus_cyc_o && prev_hold) begin
        check("hold_we",   32'(bus_we_o),  32'(prev_req.we));
        check("hold_sel",  32'(bus_sel_o), 32'(prev_req.sel));
        check("hold_addr", bus_addr_o,     prev_req.addr);
        check("hold_data", bus_data_o,     prev_req.data);
      end
      if (bus_cyc_o && bus_ack_i) begin
        if (bus_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got addr 0x%08h with no transaction expected at %0t", bus_addr_o, $time);
        end else begin
          be = bus_exp_q.pop_front();
          check("bus_we",   32'(bus_we_o),  32'(be.we));
          check("bus_sel",  32'(bus_sel_o), 32'(be.sel));
          check("bus_addr", bus_addr_o,     be.addr);
          if (be.chk_data) check("bus_wdata", bus_data_o, be.data);
        end
      end
      prev_req  = '{we: bus_we_o, sel: bus_sel_o, addr: bus_addr_o, data: bus_data_o, chk_data: 1'b1};
      prev_hold = bus_cyc_o && !bus_ack_i;
      ack_last  = bus_cyc_o && bus_ack_i;

      mem_done = mem_ce_i && !mem_stallreq_o;
      if_done  = if_ce_i && !if_stallreq_o;
      if (mem_done) begin
        if (done_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_done_unexpected: got data 0x%08h with no completion expected at %0t", mem_data_o, $time);
        end else begin
          de = done_exp_q.pop_front();
          check("done_is_data", 32'(de.is_data), 32'h1);
          if (de.chk_data) check("mem_data", mem_data_o, de.data);
        end
      end else begin
        check("mem_data_zero", mem_data_o, 32'h0);
      end
      if (if_done) begin
        if (done_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_done_unexpected: got data 0x%08h with no completion expected at %0t", if_data_o, $time);
        end else begin
          de = done_exp_q.pop_front();
          check("done_is_inst", 32'(de.is_data), 32'h0);
          if (de.chk_data) check("if_data", if_data_o, de.data);
        end
      end else begin
        check("if_data_zero", if_data_o, 32'h0);
      end
    end
  end

  // Count stalled cycles from the request cycle up to the completion cycle.
  task automatic wait_done(input bit is_data, input string name, input int exp_stalls);
    int stalls = 0;
    bit done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (is_data ? mem_stallreq_o : if_stallreq_o) stalls++;
      else done = 1'b1;
    end
    check({name, "_completed"}, 32'(done), 32'h1);
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic data_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input int aw, input logic [31:0] rdata,
                             input int exp_stalls, input string name);
    ack_wait = aw;
    if (!we) rdata_q.push_back(rdata);
    bus_exp_q.push_back('{we: we, sel: sel, addr: addr, data: wdata, chk_data: 1'b1});
    done_exp_q.push_back('{is_data: 1'b1, chk_data: !we, data: rdata});
    mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_data_i = wdata;
    wait_done(1'b1, name, exp_stalls);
    step();
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step();
  endtask

  task automatic inst_access(input logic [31:0] addr, input int aw, input logic [31:0] rdata,
                             input int exp_stalls, input string name);
    ack_wait = aw;
    rdata_q.push_back(rdata);
    bus_exp_q.push_back('{we: 1'b0, sel: 4'b1111, addr: addr, data: 32'h0, chk_data: 1'b0});
    done_exp_q.push_back('{is_data: 1'b0, chk_data: 1'b1, data: rdata});
    if_ce_i = 1'b1; if_addr_i = addr;
    wait_done(1'b0, name, exp_stalls);
    step();
    if_ce_i = 1'b0;
    step();
  endtask

  initial begin
    // Reset values, with both requests high so the stalls follow ce.
    rst = 1'b1; if_ce_i = 1'b1; mem_ce_i = 1'b1;
    @(negedge clk);
    check("rst_cyc",       32'(bus_cyc_o),      32'h0);
    check("rst_stb",       32'(bus_stb_o),      32'h0);
    check("rst_we",        32'(bus_we_o),       32'h0);
    check("rst_sel",       32'(bus_sel_o),      32'h0);
    check("rst_addr",      bus_addr_o,          32'h0);
    check("rst_wdata",     bus_data_o,          32'h0);
    check("rst_if_data",   if_data_o,           32'h0);
    check("rst_mem_data",  mem_data_o,          32'h0);
    check("rst_if_stall",  32'(if_stallreq_o),  32'h1);
    check("rst_mem_stall", 32'(mem_stallreq_o), 32'h1);
    step();
    rst = 1'b0; if_ce_i = 1'b0; mem_ce_i = 1'b0;
    step();

    // Single read, ack at cycle 2: three stalled cycles.
    data_access(1'b0, 4'b1111, 32'h100, 32'h0, 1, 32'hDEADBEEF, 3, "read");

    // Zero-wait write: stall low at cycle 2.
    data_access(1'b1, 4'b0011, 32'h300, 32'h0000ABCD, 0, 32'h0, 2, "write");

    // Plain fetch, ack at cycle 4.
    inst_access(32'h80, 3, 32'h2108_0004, 5, "fetch");

    // Simultaneous requests: data first, IF still stalled in DONE_DATA.
    ack_wait = 0;
    rdata_q.push_back(32'h1111_2222);
    rdata_q.push_back(32'h3333_4444);
    bus_exp_q.push_back('{we: 1'b0, sel: 4'b0101, addr: 32'h200, data: 32'hCAFE_0000, chk_data: 1'b1});
    bus_exp_q.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h0,   data: 32'h0,         chk_data: 1'b0});
    done_exp_q.push_back('{is_data: 1'b1, chk_data: 1'b1, data: 32'h1111_2222});
    done_exp_q.push_back('{is_data: 1'b0, chk_data: 1'b1, data: 32'h3333_4444});
    if_ce_i = 1'b1; if_addr_i = 32'h0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b0101; mem_addr_i = 32'h200; mem_data_i = 32'hCAFE_0000;
    wait_done(1'b1, "simul_data", 2);
    check("simul_if_stall_in_done_data", 32'(if_stallreq_o), 32'h1);
    step();
    mem_ce_i = 1'b0;
    wait_done(1'b0, "simul_inst", 2);
    step();
    if_ce_i = 1'b0;
    step();

    // Flush pulse during BUS_INST: fetch completes on the bus but is dropped.
    ack_wait = 2;
    rdata_q.push_back(32'h2402_0001);
    bus_exp_q.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h40, data: 32'h0, chk_data: 1'b0});
    if_ce_i = 1'b1; if_addr_i = 32'h40;          // cycle 0, IDLE
    step(); flush_i = 1'b1;                      // cycle 1, BUS_INST
    @(negedge clk);
    check("flush_cyc_during", 32'(bus_cyc_o), 32'h1);
    step(); flush_i = 1'b0;                      // cycle 2
    step();                                      // cycle 3, ack
    step(); flush_i = 1'b1;                      // cycle 4, back in IDLE; flush blocks regrant
    @(negedge clk);
    check("flush_idle_cyc",   32'(bus_cyc_o),     32'h0);
    check("flush_if_stall",   32'(if_stallreq_o), 32'h1);
    check("flush_if_data",    if_data_o,          32'h0);
    step(); flush_i = 1'b0; if_ce_i = 1'b0;      // cycle 5
    @(negedge clk);
    check("flush_no_regrant", 32'(bus_cyc_o),     32'h0);
    step();

    // Reset in the middle of a data access.
    ack_wait = 10;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h500; mem_data_i = 32'h5555_AAAA;
    step();                                      // cycle 1, BUS_DATA
    @(negedge clk);
    check("pre_rst_cyc",  32'(bus_cyc_o), 32'h1);
    check("pre_rst_addr", bus_addr_o,     32'h500);
    step(); rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    check("midrst_cyc",       32'(bus_cyc_o),      32'h0);
    check("midrst_stb",       32'(bus_stb_o),      32'h0);
    check("midrst_we",        32'(bus_we_o),       32'h0);
    check("midrst_sel",       32'(bus_sel_o),      32'h0);
    check("midrst_addr",      bus_addr_o,          32'h0);
    check("midrst_wdata",     bus_data_o,          32'h0);
    check("midrst_mem_data",  mem_data_o,          32'h0);
    check("midrst_mem_stall", 32'(mem_stallreq_o), 32'h0);
    step();
    data_access(1'b0, 4'b1111, 32'h600, 32'h0, 0, 32'h1234_5678, 2, "post_rst_read");

    // Long wait: ack 20 cycles after the request, bus fields held meanwhile.
    data_access(1'b1, 4'b1100, 32'h700, 32'h55AA_55AA, 19, 32'h0, 21, "long_wait");

    repeat (2) step();
    check("bus_queue_empty",  32'(bus_exp_q.size()),  32'h0);
    check("done_queue_empty", 32'(done_exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
